// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared enums for the multicycle MIPS core
package cpu_types_pkg;
    typedef enum logic [2:0] {PC_NEXT, PC_BEQ, PC_BNE, PC_JUMP, PC_JR} pcselect_t;
    typedef enum logic [1:0] {FETCH, EXEC, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache, control-unit and datapath signals of the fetch stage
interface fetch_unit_if;
    logic                     ihit;
    logic [31:0]              iload;
    logic                     iREN;
    logic [31:0]              iaddr;
    logic [31:0]              imemload;
    logic                     instr_valid;
    cpu_types_pkg::pcselect_t pc_select;
    logic [31:0]              jump_data;
    logic [31:0]              immediate;
    logic                     zero;
    logic                     stall;
    logic                     halt;
    logic                     halted;
    logic [31:0]              npc;
    modport fu (
        input  ihit, iload, pc_select, jump_data, immediate, zero, stall, halt,
        output iREN, iaddr, imemload, instr_valid, halted, npc
    );
    modport tb (
        output ihit, iload, pc_select, jump_data, immediate, zero, stall, halt,
        input  iREN, iaddr, imemload, instr_valid, halted, npc
    );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// fetch_unit_next_pc: combinational next-PC mux with link and branch adders
module fetch_unit_next_pc
    import cpu_types_pkg::*;
(
    input  logic [31:0] pc,
    input  pcselect_t   pc_select,
    input  logic [31:0] jump_data,
    input  logic [31:0] immediate,
    input  logic        zero,
    output logic [31:0] npc,
    output logic [31:0] next_pc
);
    logic [31:0] target;
    logic        taken;
    always_comb begin
        npc     = pc + 32'd4;
        target  = npc + (immediate << 2);
        taken   = (pc_select == PC_BEQ && zero) || (pc_select == PC_BNE && !zero);
        next_pc = pc_select == PC_JR   ? (jump_data & 32'hFFFF_FFFC) :
                  pc_select == PC_JUMP ? {npc[31:28], jump_data[25:0], 2'b00} :
                  taken                ? target : npc;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch/exec/halt sequencing of the multicycle core
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic       CLK,
    input  logic       RST,
    fetch_unit_if.fu   fif
);
    fetch_state_t state;
    logic [31:0]  pc, ir, next_pc, npc;
    logic         halted_q;
    fetch_unit_next_pc u_next_pc (
        .pc        (pc),
        .pc_select (fif.pc_select),
        .jump_data (fif.jump_data),
        .immediate (fif.immediate),
        .zero      (fif.zero),
        .npc       (npc),
        .next_pc   (next_pc)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc       <= PC_INIT;
            ir       <= '0;
            state    <= FETCH;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: if (fif.ihit) begin
                    ir    <= fif.iload;
                    state <= EXEC;
                end
                EXEC: if (fif.halt) begin
                    halted_q <= 1'b1;
                    state    <= HALTED;
                end else if (!fif.stall) begin
                    pc    <= next_pc;
                    state <= FETCH;
                end
                default: ;
            endcase
        end
    end
    // Outputs are forced quiet while RST is held, even before the first edge.
    assign fif.iREN        = !RST && state == FETCH;
    assign fif.instr_valid = !RST && state == EXEC;
    assign fif.halted      = !RST && halted_q;
    assign fif.imemload    = RST ? 32'h0 : ir;
    assign fif.iaddr       = pc;
    assign fif.npc         = npc;
endmodule
